// File: rtl/count_monitor.sv
// -----------------------------------------------------------------------------
// count_monitor
//
// Watches a free-running modulo-M counter and the decode pulse that goes with
// it. The monitor locks onto the counter sequence, checks every qualified
// sample, and reports errors and completed wraps. All outputs are registered.
// A sample taken on clock edge k is reflected on the outputs after edge k+1.
//
// Parameters
//   M          modulus of the observed counter (legal values 0..M-1)
//   N          width of the count bus (2**N >= M)
//   PULSE_VAL  count value at which pulse_in_i is expected high
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   en_i          sample qualifier; inputs are evaluated only when high
//   count_in_i    observed counter value
//   pulse_in_i    observed decode pulse
//   clr_err_i     synchronous clear of err_count_o / err_sticky_o
//   locked_o      high once a full valid wrap has been seen while tracking
//   err_pulse_o   one-cycle flag: the previous sample was errored
//   err_sticky_o  set by any error, held until clr_err_i or reset
//   err_count_o   saturating (255) count of errored samples
//   wrap_count_o  modulo-256 count of completed wraps (M-1 -> 0) in TRACK
//   state_o       debug view of the FSM state (0 IDLE, 1 SYNC, 2 TRACK)
//   expected_o    debug view of the next expected count value
//
// Handshake: there is no backpressure. en_i acts as a valid strobe for the
// observed bus; every cycle with en_i=1 is one sample and is consumed in that
// cycle. Cycles with en_i=0 freeze all tracking state and counters.
// -----------------------------------------------------------------------------
module count_monitor #(
  parameter int M         = 7,
  parameter int N         = 3,
  parameter int PULSE_VAL = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [N-1:0] count_in_i,
  input  logic         pulse_in_i,
  input  logic         clr_err_i,
  output logic         locked_o,
  output logic         err_pulse_o,
  output logic         err_sticky_o,
  output logic [7:0]   err_count_o,
  output logic [7:0]   wrap_count_o,
  output logic [1:0]   state_o,
  output logic [N-1:0] expected_o
);

  // ---------------------------------------------------------------------------
  // Constants, sized to the buses they are compared against
  // ---------------------------------------------------------------------------
  localparam logic [N:0]   M_EXT   = (N+1)'(M);
  localparam logic [N-1:0] LAST    = N'(M - 1);
  localparam logic [N-1:0] PULSE_V = N'(PULSE_VAL);
  localparam logic [N-1:0] ONE     = N'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e         state_q,      state_d;
  logic [N-1:0]   expected_q,   expected_d;
  logic           prev_zero_q,  prev_zero_d;
  logic           locked_q,     locked_d;
  logic           err_pulse_q,  err_pulse_d;
  logic           err_sticky_q, err_sticky_d;
  logic [7:0]     err_count_q,  err_count_d;
  logic [7:0]     wrap_count_q, wrap_count_d;

  // ---------------------------------------------------------------------------
  // Sample decode
  // ---------------------------------------------------------------------------
  logic         in_range;
  logic         is_zero;
  logic         pulse_bad;
  logic [N-1:0] next_exp;

  assign in_range  = {1'b0, count_in_i} < M_EXT;
  assign is_zero   = (count_in_i == '0);
  assign pulse_bad = pulse_in_i != (count_in_i == PULSE_V);
  // Successor of the current sample in the modulo-M sequence.
  assign next_exp  = (count_in_i == LAST) ? '0 : count_in_i + ONE;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      expected_q  <= '0;
      prev_zero_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      prev_zero_q <= prev_zero_d;
      locked_q    <= locked_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, sequence errors and wrap detection
  // ---------------------------------------------------------------------------
  logic seq_err;
  logic pulse_err;
  logic err_any;
  logic wrap_inc;

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    prev_zero_d = prev_zero_q;
    locked_d    = locked_q;
    seq_err     = 1'b0;
    wrap_inc    = 1'b0;

    if (en_i) begin
      // Remembers whether the most recent sample was 0, so that a repeated 0
      // in TRACK is treated as a re-anchor rather than a mismatch.
      prev_zero_d = is_zero;

      case (state_q)
        IDLE: begin
          if (!in_range) begin
            seq_err = 1'b1;
            state_d = SYNC;
          end else if (is_zero) begin
            state_d    = TRACK;
            expected_d = ONE;
          end else begin
            state_d = SYNC;
          end
        end

        SYNC: begin
          if (!in_range) begin
            seq_err = 1'b1;
          end else if (is_zero) begin
            state_d    = TRACK;
            expected_d = ONE;
            locked_d   = 1'b0;
          end
        end

        TRACK: begin
          if (!in_range) begin
            seq_err  = 1'b1;
            locked_d = 1'b0;
            state_d  = SYNC;
          end else if (count_in_i == expected_q) begin
            expected_d = next_exp;
            // A matching 0 can only follow a matching M-1: that is a wrap.
            if (is_zero) begin
              wrap_inc = 1'b1;
              locked_d = 1'b1;
            end
          end else if (is_zero) begin
            // Unexpected 0: re-anchor in place. Back-to-back zeros are
            // harmless; a 0 out of the blue is an error and drops lock.
            expected_d = ONE;
            if (!prev_zero_q) begin
              seq_err  = 1'b1;
              locked_d = 1'b0;
            end
          end else begin
            seq_err  = 1'b1;
            locked_d = 1'b0;
            state_d  = SYNC;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Pulse consistency is checked once the monitor is engaged; it never
  // changes the tracking state. Any mix of causes counts as one error.
  assign pulse_err = en_i && (state_q != IDLE) && pulse_bad;
  assign err_any   = seq_err || pulse_err;

  // ---------------------------------------------------------------------------
  // Error and wrap bookkeeping
  // ---------------------------------------------------------------------------
  logic [7:0] err_count_base;
  logic       err_sticky_base;

  always_comb begin
    // Clear is applied first so a clear coinciding with an error leaves the
    // new error recorded.
    err_count_base  = clr_err_i ? 8'd0 : err_count_q;
    err_sticky_base = clr_err_i ? 1'b0 : err_sticky_q;

    err_count_d = err_count_base;
    if (err_any && (err_count_base != 8'hFF)) begin
      err_count_d = err_count_base + 8'd1;
    end

    err_sticky_d = err_sticky_base | err_any;
    err_pulse_d  = err_any;
    wrap_count_d = wrap_inc ? wrap_count_q + 8'd1 : wrap_count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= 8'd0;
      wrap_count_q <= 8'd0;
    end else begin
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign locked_o     = locked_q;
  assign err_pulse_o  = err_pulse_q;
  assign err_sticky_o = err_sticky_q;
  assign err_count_o  = err_count_q;
  assign wrap_count_o = wrap_count_q;
  assign state_o      = state_q;
  assign expected_o   = expected_q;

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter M, default 7: modulus of the observed counter; legal count values are 0..M-1.
REQ-002 Parameter N, default 3: width of the count bus; 2^N SHALL be >= M.
REQ-003 Parameter PULSE_VAL, default 4: count value at which the companion pulse is expected.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  sample qualifier; count_in and pulse_in are evaluated only on cycles with en=1.
REQ-007 count_in  input  N  observed counter value.
REQ-008 pulse_in  input  1  observed decode pulse.
REQ-009 clr_err  input  1  synchronous clear of err_count and err_sticky.
REQ-010 locked  output  1  high while tracking a valid sequence for at least one full wrap.
REQ-011 err_pulse  output  1  one-cycle flag for any error detected on the previous sample.
REQ-012 err_sticky  output  1  set by any error; held until clr_err or reset.
REQ-013 err_count  output  8  saturating count of errored samples.
REQ-014 wrap_count  output  8  modulo-256 count of completed wraps (M-1 -> 0) while in TRACK.

Function
REQ-015 FSM states SHALL be IDLE, SYNC and TRACK; all outputs SHALL be registered.
REQ-016 IDLE: on the first en=1 sample, go to SYNC, or go directly to TRACK with expected=1 if count_in=0.
REQ-017 SYNC: sample with count_in=0 -> TRACK with expected=1; any other value -> stay in SYNC; repeated 0 samples re-anchor (no error).
REQ-018 TRACK: each sample is compared against expected; expected SHALL advance as (count_in+1) wrapping M-1 -> 0.
REQ-019 TRACK, count_in != expected: raise error, locked -> 0, go to SYNC; a mismatch sample equal to 0 re-anchors immediately (stay in TRACK, expected=1, locked -> 0).
REQ-020 TRACK, count_in=0 immediately after count_in=0: not an error; treat as re-anchor (expected=1, locked unchanged).
REQ-021 TRACK, sample with count_in=M-1 followed by matching sample 0: wrap_count increments by 1 and locked -> 1.
REQ-022 Pulse check in SYNC and TRACK: pulse_in SHALL equal (count_in == PULSE_VAL); mismatch raises error but does not change state.
REQ-023 Count value >= M in any state: raise error; in TRACK, go to SYNC.
REQ-024 Multiple error causes on one sample count as one error.
REQ-025 err_pulse SHALL be high exactly the cycle after an errored sample; err_sticky and err_count update in the same cycle.
REQ-026 err_count SHALL saturate at 255.
REQ-027 clr_err coincident with a new error: err_count=1, err_sticky=1 (clear applied first).
REQ-028 en=0: state, expected, counters and flags hold; err_pulse=0.
REQ-029 Latency: sample at edge k -> outputs valid after edge k+1.

Reset
REQ-030 Reset SHALL force state=IDLE, expected=0, locked=0, err_pulse=0, err_sticky=0, err_count=0, wrap_count=0.
REQ-031 Reset mid-operation SHALL abandon tracking immediately; no error is reported for the interrupted sequence.

Verification
REQ-032 Reset, en=1, feed 0,0,1,2,3,4,5,6,0 with pulse only at 4 -> no errors, locked=1 after final 0, wrap_count=1.
REQ-033 Locked stream, skip 3 (2 -> 4, pulse correct) -> err_pulse one cycle, err_count=1, locked=0, state SYNC; next 0 resumes TRACK.
REQ-034 Correct count sequence, pulse_in high at count 5 -> err_count=1, locked stays 1, wrap_count continues.
REQ-035 count_in=7 with M=7 -> err_count+1, state SYNC.
REQ-036 Force 300 errored samples -> err_count=255; then clr_err alone -> err_count=0, err_sticky=0; clr_err with error -> err_count=1.
REQ-037 Toggle en=0 for 5 cycles mid-sequence with count_in frozen -> no errors, counters unchanged; assert reset mid-wrap -> all outputs 0 next cycle.
